// File: rtl/mm_tile_sched.sv
// Tile scheduler for a ROW_NUM x COL_NUM x LENGTH matrix-multiply array.
// Walks an M x N x K tile space (k innermost), issues one tile per cycle
// while the downstream grants credit, and delays the tile tags by the
// array's pipeline depth so results leave tagged with their (m,n) and K flags.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; a rejected config is flagged here first
//   ISSUE  | presenting tiles to the array, advancing on out_ready_i
//   DRAIN  | all tiles issued, waiting for in-flight results to emerge
//   DONE   | one-cycle completion pulse, then back to IDLE
module mm_tile_sched #(
  parameter int ROW_NUM   = 8,
  parameter int COL_NUM   = 8,
  parameter int LENGTH    = 8,
  parameter int ARRAY_LAT = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cfg_m_tiles_i,
  input  logic [CNT_WIDTH-1:0] cfg_n_tiles_i,
  input  logic [CNT_WIDTH-1:0] cfg_k_tiles_i,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_cfg_o,
  output logic                 issue_valid_o,
  output logic [CNT_WIDTH-1:0] issue_m_o,
  output logic [CNT_WIDTH-1:0] issue_n_o,
  output logic [CNT_WIDTH-1:0] issue_k_o,
  output logic                 issue_first_k_o,
  output logic                 issue_last_k_o,
  output logic                 res_valid_o,
  output logic [CNT_WIDTH-1:0] res_m_o,
  output logic [CNT_WIDTH-1:0] res_n_o,
  output logic                 res_first_k_o,
  output logic                 res_last_k_o
);

  if (ARRAY_LAT < 1) begin : g_bad_lat
    $error("mm_tile_sched: ARRAY_LAT must be at least 1");
  end
  if (ROW_NUM < 1 || COL_NUM < 1 || LENGTH < 1) begin : g_bad_geom
    $error("mm_tile_sched: array geometry must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [CNT_WIDTH-1:0] m;
    logic [CNT_WIDTH-1:0] n;
    logic                 first_k;
    logic                 last_k;
  } tag_t;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  // Latched counts minus one: the wrap compare never needs count itself,
  // so a count of all-ones cannot overflow the compare.
  logic [CNT_WIDTH-1:0] m_max_q, m_max_d, n_max_q, n_max_d, k_max_q, k_max_d;
  logic                 err_q, err_d;
  tag_t                 pipe_q [ARRAY_LAT];
  tag_t                 tag_in;
  logic                 inflight;
  logic                 cfg_zero;

  assign cfg_zero = (cfg_m_tiles_i == '0) || (cfg_n_tiles_i == '0) ||
                    (cfg_k_tiles_i == '0);

  assign issue_valid_o   = (state_q == S_ISSUE) && out_ready_i;
  assign issue_m_o       = m_q;
  assign issue_n_o       = n_q;
  assign issue_k_o       = k_q;
  assign issue_first_k_o = (state_q == S_ISSUE) && (k_q == '0);
  assign issue_last_k_o  = (state_q == S_ISSUE) && (k_q == k_max_q);
  assign busy_o          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o          = (state_q == S_DONE);
  assign err_cfg_o       = err_q;

  assign res_valid_o   = pipe_q[ARRAY_LAT-1].valid;
  assign res_m_o       = pipe_q[ARRAY_LAT-1].m;
  assign res_n_o       = pipe_q[ARRAY_LAT-1].n;
  assign res_first_k_o = pipe_q[ARRAY_LAT-1].first_k;
  assign res_last_k_o  = pipe_q[ARRAY_LAT-1].last_k;

  // Tag entering the delay line; zero when nothing issues so res_* stay 0.
  always_comb begin
    tag_in = '0;
    if (issue_valid_o) begin
      tag_in.valid   = 1'b1;
      tag_in.m       = m_q;
      tag_in.n       = n_q;
      tag_in.first_k = issue_first_k_o;
      tag_in.last_k  = issue_last_k_o;
    end
  end

  // Any valid tag that will still be in the line after this cycle's output.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < ARRAY_LAT - 1; i++) begin
      inflight = inflight | pipe_q[i].valid;
    end
  end

  // Next-state, tile-walk counters and config latch.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    m_max_d = m_max_q;
    n_max_d = n_max_q;
    k_max_d = k_max_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (err_q) begin
          state_d = S_DONE;
        end else if (start_i) begin
          if (cfg_zero) begin
            err_d = 1'b1;
          end else begin
            m_max_d = cfg_m_tiles_i - 1'b1;
            n_max_d = cfg_n_tiles_i - 1'b1;
            k_max_d = cfg_k_tiles_i - 1'b1;
            m_d     = '0;
            n_d     = '0;
            k_d     = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (out_ready_i) begin
          if (k_q == k_max_q) begin
            k_d = '0;
            if (n_q == n_max_q) begin
              n_d = '0;
              if (m_q == m_max_q) begin
                m_d     = '0;
                state_d = S_DRAIN;
              end else begin
                m_d = m_q + 1'b1;
              end
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!inflight) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, counters and latched config.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      m_max_q <= '0;
      n_max_q <= '0;
      k_max_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      m_max_q <= m_max_d;
      n_max_q <= n_max_d;
      k_max_q <= k_max_d;
      err_q   <= err_d;
    end
  end

  // Tag delay line matching the array latency; never stalls.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < ARRAY_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < ARRAY_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_mm_tile_sched.sv
// Directed bench for mm_tile_sched: a queue-based job model predicts every
// output each cycle, and per-job timing/mask literals pin that model.
module tb_mm_tile_sched;
  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic         out_ready = 1'b1;
  logic         busy, done, err_cfg, iv, ifk, ilk, rv, rfk, rlk;
  logic [W-1:0] im, in_, ik, rm, rn;

  mm_tile_sched #(.ROW_NUM(8), .COL_NUM(8), .LENGTH(8), .ARRAY_LAT(L), .CNT_WIDTH(W)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start),
    .cfg_m_tiles_i(cfg_m), .cfg_n_tiles_i(cfg_n), .cfg_k_tiles_i(cfg_k),
    .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .err_cfg_o(err_cfg),
    .issue_valid_o(iv), .issue_m_o(im), .issue_n_o(in_), .issue_k_o(ik),
    .issue_first_k_o(ifk), .issue_last_k_o(ilk),
    .res_valid_o(rv), .res_m_o(rm), .res_n_o(rn),
    .res_first_k_o(rfk), .res_last_k_o(rlk)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] m, n, k; } iss_t;
  typedef struct packed { logic v; logic [W-1:0] m, n; logic fk, lk; } tag_t;

  iss_t exp_q[$];
  tag_t dl[L];
  int   ph = 0;   // 0 idle, 1 issuing, 2 draining, 3 done, 4 config error
  int   mK = 1;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0 = 0;
  int n_iss, n_res, n_done, busy_cnt, done_rel, err_rel;
  logic [63:0] iss_mask, res_mask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_iss = 0; n_res = 0; n_done = 0; busy_cnt = 0;
    done_rel = -1; err_rel = -1;
    iss_mask = '0; res_mask = '0;
  endtask

  // Model and per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    iss_t cur;
    tag_t nt;
    logic e_iv, any;
    int   rel;
    if (!rst_n) begin
      chk("reset_outputs",
          {busy, done, err_cfg, iv, im, in_, ik, ifk, ilk, rv, rm, rn, rfk, rlk}, '0);
      ph = 0;
      exp_q.delete();
      for (int i = 0; i < L; i++) dl[i] = '0;
    end else begin
      cur  = (exp_q.size() > 0) ? exp_q[0] : '0;
      e_iv = (ph == 1) && out_ready;
      chk("ctrl", {busy, done, err_cfg, iv},
          {(ph == 1 || ph == 2), (ph == 3), (ph == 4), e_iv});
      if (ph == 1)
        chk("issue_idx", {im, in_, ik, ifk, ilk},
            {cur.m, cur.n, cur.k, (int'(cur.k) == 0), (int'(cur.k) == mK - 1)});
      chk("res_tag", {rv, rm, rn, rfk, rlk}, dl[L-1]);

      rel = cyc - t0;
      if (iv) begin n_iss++; if (rel >= 0 && rel < 64) iss_mask[rel] = 1'b1; end
      if (rv) begin n_res++; if (rel >= 0 && rel < 64) res_mask[rel] = 1'b1; end
      if (busy) busy_cnt++;
      if (done) begin n_done++; if (done_rel < 0) done_rel = rel; end
      if (err_cfg && err_rel < 0) err_rel = rel;

      for (int i = L - 1; i > 0; i--) dl[i] = dl[i-1];
      nt = '0;
      if (e_iv) begin
        nt.v = 1'b1; nt.m = cur.m; nt.n = cur.n;
        nt.fk = (int'(cur.k) == 0); nt.lk = (int'(cur.k) == mK - 1);
      end
      dl[0] = nt;
      case (ph)
        0: if (start) begin
             if (cfg_m == 0 || cfg_n == 0 || cfg_k == 0) ph = 4;
             else begin
               mK = int'(cfg_k);
               for (int a = 0; a < int'(cfg_m); a++)
                 for (int b = 0; b < int'(cfg_n); b++)
                   for (int c = 0; c < int'(cfg_k); c++)
                     exp_q.push_back('{m: W'(a), n: W'(b), k: W'(c)});
               ph = 1;
             end
           end
        1: if (e_iv) begin
             void'(exp_q.pop_front());
             if (exp_q.size() == 0) ph = 2;
           end
        2: begin
             any = 1'b0;
             for (int i = 0; i < L; i++) any = any | dl[i].v;
             if (!any) ph = 3;
           end
        3: ph = 0;
        default: ph = 3;
      endcase
    end
  end

  // Runs one job; out_ready low on rel cycles slo..shi, or random if rnd.
  // A start re-pulse with a different config is driven at rel cycle rp.
  task automatic run_job(input int m, input int n, input int k, input int slo,
                         input int shi, input int rp, input bit rnd, input int maxc);
    int rel;
    clear_stats();
    @(posedge clk); #1;
    cfg_m = W'(m); cfg_n = W'(n); cfg_k = W'(k);
    start = 1'b1; out_ready = 1'b1; t0 = cyc;
    rel = 0;
    while (done_rel < 0 && rel < maxc) begin
      @(posedge clk); #1;
      rel++;
      start = (rel == rp);
      if (rel == rp) begin cfg_m = 1; cfg_n = 1; cfg_k = 1; end
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(rel >= slo && rel <= shi);
    end
    start = 1'b0; out_ready = 1'b1;
    chk("done_seen", done_rel >= 0, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job(2, 2, 2, -1, -1, -1, 0, 100);
    chk("j222_iss_mask", iss_mask, 64'h1FE);
    chk("j222_res_mask", res_mask, 64'h1FE0);
    chk("j222_done_rel", done_rel, 13);
    chk("j222_busy_cycles", busy_cnt, 12);
    chk("j222_done_count", n_done, 1);

    run_job(1, 1, 1, -1, -1, -1, 0, 100);
    chk("j111_iss_mask", iss_mask, 64'h2);
    chk("j111_res_mask", res_mask, 64'h20);
    chk("j111_done_rel", done_rel, 6);

    run_job(3, 0, 2, -1, -1, -1, 0, 100);
    chk("err_rel", err_rel, 1);
    chk("err_done_rel", done_rel, 2);
    chk("err_no_issue", n_iss, 0);
    chk("err_no_res", n_res, 0);
    chk("err_not_busy", busy_cnt, 0);

    run_job(1, 2, 3, 3, 6, -1, 0, 100);
    chk("stall_iss_mask", iss_mask, 64'h786);
    chk("stall_res_mask", res_mask, 64'h7860);
    chk("stall_issues", n_iss, 6);
    chk("stall_done_rel", done_rel, 15);

    run_job(2, 2, 2, -1, -1, 3, 0, 100);
    chk("repulse_iss_mask", iss_mask, 64'h1FE);
    chk("repulse_done_rel", done_rel, 13);

    run_job(1, 1, 255, -1, -1, -1, 0, 400);
    chk("kmax_issues", n_iss, 255);
    chk("kmax_results", n_res, 255);
    chk("kmax_done_rel", done_rel, 260);

    run_job(2, 3, 2, -1, -1, -1, 1, 300);
    chk("rnd_issues", n_iss, 12);
    chk("rnd_results", n_res, 12);

    // Reset in cycle 6 of a 2x2x2 job: abandon, no done pulse.
    clear_stats();
    @(posedge clk); #1;
    cfg_m = 2; cfg_n = 2; cfg_k = 2; start = 1'b1; t0 = cyc;
    for (int r = 1; r <= 6; r++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (r == 6) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("abort_no_done", n_done, 0);
    chk("abort_issues", n_iss, 5);
    chk("abort_results", n_res, 1);

    run_job(1, 1, 1, -1, -1, -1, 0, 100);
    chk("after_reset_done_rel", done_rel, 6);
    chk("after_reset_res_mask", res_mask, 64'h20);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
